// File: rtl/register_bank_pkg.sv
// Shared defaults and constants for the register bank and its read ports.
package register_bank_pkg;

   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_NREGS = 32;
   localparam int unsigned DEF_NREAD = 2;
   localparam int unsigned ZERO_IDX  = 0;

   // Address width for a given register count; at least one bit.
   function automatic int unsigned addr_width(input int unsigned nregs);
      return (nregs > 1) ? $clog2(nregs) : 1;
   endfunction

endpackage

// File: rtl/register_bank_if.sv
// Decode/writeback-facing bus of the register bank.
interface register_bank_if
   import register_bank_pkg::*;
#(
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned NREGS = DEF_NREGS,
   parameter int unsigned NREAD = DEF_NREAD
);

   localparam int unsigned AW = addr_width(NREGS);

   logic                  RegWrite;
   logic [AW-1:0]         writeReg;
   logic [XLEN-1:0]       writeData;
   logic [NREAD*AW-1:0]   readReg;
   logic [NREAD*XLEN-1:0] readData;
   logic                  issueValid;
   logic [AW-1:0]         issueReg;
   logic                  flush;
   logic [NREAD-1:0]      busy;

   // Pipeline side: drives addresses, writes and issues.
   modport master (
      output RegWrite, writeReg, writeData, readReg, issueValid, issueReg, flush,
      input  readData, busy
   );

   // Register bank side.
   modport slave (
      input  RegWrite, writeReg, writeData, readReg, issueValid, issueReg, flush,
      output readData, busy
   );

endinterface

// File: rtl/register_bank_rdport.sv
// One read port: storage mux, x0 mask, write bypass and busy mask.
module register_bank_rdport
   import register_bank_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned AW       = addr_width(NREGS)
) (
   input  logic [NREGS-1:0][XLEN-1:0] regs,
   input  logic [NREGS-1:0]           sb,
   input  logic                       hold,     // reset active: suppress bypass
   input  logic [AW-1:0]              addr,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   output logic [XLEN-1:0]            data,
   output logic                       busy
);

   logic hit;
   logic is_zero;

   // Resolve data and busy for this port; x0 masking overrides the bypass.
   always_comb begin
      hit     = (BYPASS != 0) && !hold && wr_en && (wr_addr == addr);
      is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_IDX));
      data    = regs[addr];
      busy    = sb[addr];
      if (hit) begin
         data = wr_data;
         busy = 1'b0;
      end
      if (is_zero) begin
         data = '0;
         busy = 1'b0;
      end
   end

endmodule

// File: rtl/register_bank.sv
// RISC-V integer register file with busy scoreboard and per-port bypass.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int unsigned XLEN     = DEF_XLEN,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned NREAD    = DEF_NREAD,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input logic          clock,
   input logic          reset,
   register_bank_if.slave bus
);

   localparam int unsigned AW = addr_width(NREGS);

   logic [NREGS-1:0][XLEN-1:0] regs;
   logic [NREGS-1:0]           sb;
   logic [NREGS-1:0]           sb_next;
   logic                       wr_ok;
   logic                       issue_ok;

   // Qualify write and issue; x0 never stores data or becomes busy.
   always_comb begin
      wr_ok    = bus.RegWrite &&
                 !((ZERO_REG != 0) && (bus.writeReg == AW'(ZERO_IDX)));
      issue_ok = bus.issueValid &&
                 !((ZERO_REG != 0) && (bus.issueReg == AW'(ZERO_IDX)));
   end

   // Scoreboard next state: flush beats issue, a new producer beats writeback.
   always_comb begin
      sb_next = sb;
      if (bus.flush) begin
         sb_next = '0;
      end else begin
         if (bus.RegWrite && !(bus.issueValid && (bus.issueReg == bus.writeReg))) begin
            sb_next[bus.writeReg] = 1'b0;
         end
         if (issue_ok) begin
            sb_next[bus.issueReg] = 1'b1;
         end
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs <= '0;
      end else if (wr_ok) begin
         regs[bus.writeReg] <= bus.writeData;
      end
   end

   // Busy scoreboard with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sb <= '0;
      end else begin
         sb <= sb_next;
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rdport
      register_bank_rdport #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS),
         .AW       (AW)
      ) u_rdport (
         .regs    (regs),
         .sb      (sb),
         .hold    (reset),
         .addr    (bus.readReg[i*AW +: AW]),
         .wr_en   (bus.RegWrite),
         .wr_addr (bus.writeReg),
         .wr_data (bus.writeData),
         .data    (bus.readData[i*XLEN +: XLEN]),
         .busy    (bus.busy[i])
      );
   end

endmodule
